// File: rtl/load_store_unit_if.sv
// Signal bundle between the EX/MEM register, the load/store unit, data_memory and writeback.
// The unit connects through the slave modport; the surrounding pipeline/bench uses master.
interface load_store_unit_if;
  logic        MEM_R_En_In;
  logic        MEM_W_En_In;
  logic [2:0]  MEM_Control_In;
  logic [31:0] Addr_In;
  logic [31:0] W_Data_In;
  logic [31:0] R_Data;
  logic        MEM_W_En;
  logic [2:0]  MEM_Control;
  logic [31:0] RW_Addr;
  logic [31:0] W_Data;
  logic [31:0] Load_Data;
  logic        Stall;
  logic        Misaligned_Fault;

  modport slave (
    input  MEM_R_En_In, MEM_W_En_In, MEM_Control_In, Addr_In, W_Data_In, R_Data,
    output MEM_W_En, MEM_Control, RW_Addr, W_Data, Load_Data, Stall, Misaligned_Fault
  );

  modport master (
    output MEM_R_En_In, MEM_W_En_In, MEM_Control_In, Addr_In, W_Data_In, R_Data,
    input  MEM_W_En, MEM_Control, RW_Addr, W_Data, Load_Data, Stall, Misaligned_Fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end: aligned accesses pass straight through; misaligned ones are
// split into byte accesses when MISALIGNED_SPLIT_EN is defined, otherwise they raise a fault.
module load_store_unit (
  input  logic             CLK,
  input  logic             RST,
  load_store_unit_if.slave bus
);

  localparam logic [2:0] MEM_HALFWORD          = 3'b001;
  localparam logic [2:0] MEM_WORD              = 3'b010;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

  logic store_s;
  logic req_s;
  logic mis_s;

  // A store wins when both request lines are high.
  assign store_s = bus.MEM_W_En_In;
  assign req_s   = bus.MEM_R_En_In | bus.MEM_W_En_In;

  // Alignment check of the incoming request.
  always_comb begin
    mis_s = 1'b0;
    if (req_s) begin
      case (bus.MEM_Control_In)
        MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: mis_s = bus.Addr_In[0];
        MEM_WORD:                            mis_s = (bus.Addr_In[1:0] != 2'b00);
        default:                             mis_s = 1'b0;
      endcase
    end else begin
      mis_s = 1'b0;
    end
  end

`ifdef MISALIGNED_SPLIT_EN

  localparam logic [2:0] MEM_BYTE          = 3'b000;
  localparam logic [2:0] MEM_BYTE_UNSIGNED = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPLIT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [1:0]  last_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;
  logic [2:0]  ctrl_q;
  logic        store_q;
  logic        sel_q;

  logic        mem_w_en_s;
  logic [2:0]  mem_ctrl_s;
  logic [31:0] rw_addr_s;
  logic [31:0] w_data_s;
  logic        stall_s;
  logic [7:0]  byte_s;
  logic [31:0] ext_s;

  // Split sequencer; bytes arrive one cycle after issue and are shifted in from the top.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      asm_q   <= 32'd0;
      ctrl_q  <= 3'b000;
      store_q <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      sel_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mis_s) begin
            addr_q  <= bus.Addr_In;
            wdata_q <= bus.W_Data_In;
            ctrl_q  <= bus.MEM_Control_In;
            store_q <= store_s;
            last_q  <= (bus.MEM_Control_In == MEM_WORD) ? 2'd3 : 2'd1;
            idx_q   <= 2'd1;
            asm_q   <= 32'd0;
            state_q <= SPLIT;
          end else begin
            state_q <= IDLE;
          end
        end
        SPLIT: begin
          if (!store_q) begin
            asm_q <= {bus.R_Data[7:0], asm_q[31:8]};
          end
          if (idx_q == last_q) begin
            state_q <= FINISH;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        FINISH: begin
          if (!store_q) begin
            asm_q <= {bus.R_Data[7:0], asm_q[31:8]};
          end
          sel_q   <= ~store_q;
          idx_q   <= 2'd0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Store byte selected by the split index.
  always_comb begin
    byte_s = 8'd0;
    case (idx_q)
      2'd0:    byte_s = wdata_q[7:0];
      2'd1:    byte_s = wdata_q[15:8];
      2'd2:    byte_s = wdata_q[23:16];
      2'd3:    byte_s = wdata_q[31:24];
      default: byte_s = 8'd0;
    endcase
  end

  // A halfword ends up in the top 16 bits of the assembly register after two shifts.
  always_comb begin
    ext_s = asm_q;
    case (ctrl_q)
      MEM_HALFWORD:          ext_s = {{16{asm_q[31]}}, asm_q[31:16]};
      MEM_HALFWORD_UNSIGNED: ext_s = {16'd0, asm_q[31:16]};
      default:               ext_s = asm_q;
    endcase
  end

  // Memory-port drive: passthrough in IDLE, byte accesses while splitting.
  always_comb begin
    mem_w_en_s = store_s;
    mem_ctrl_s = bus.MEM_Control_In;
    rw_addr_s  = bus.Addr_In;
    w_data_s   = bus.W_Data_In;
    stall_s    = 1'b0;
    if (RST) begin
      mem_w_en_s = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mis_s) begin
            mem_ctrl_s = store_s ? MEM_BYTE : MEM_BYTE_UNSIGNED;
            w_data_s   = {24'd0, bus.W_Data_In[7:0]};
            stall_s    = 1'b1;
          end else begin
            stall_s    = 1'b0;
          end
        end
        SPLIT: begin
          mem_w_en_s = store_q;
          mem_ctrl_s = store_q ? MEM_BYTE : MEM_BYTE_UNSIGNED;
          rw_addr_s  = addr_q + {30'd0, idx_q};
          w_data_s   = {24'd0, byte_s};
          stall_s    = 1'b1;
        end
        FINISH: begin
          mem_w_en_s = 1'b0;
        end
        default: begin
          mem_w_en_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.MEM_W_En         = mem_w_en_s;
  assign bus.MEM_Control      = mem_ctrl_s;
  assign bus.RW_Addr          = rw_addr_s;
  assign bus.W_Data           = w_data_s;
  assign bus.Stall            = stall_s;
  assign bus.Load_Data        = sel_q ? ext_s : bus.R_Data;
  assign bus.Misaligned_Fault = 1'b0;

`else

  logic zero_q;

  // Remembers a faulted load so its writeback value is forced to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= mis_s & ~store_s;
    end
  end

  assign bus.MEM_W_En         = store_s & ~mis_s & ~RST;
  assign bus.MEM_Control      = bus.MEM_Control_In;
  assign bus.RW_Addr          = bus.Addr_In;
  assign bus.W_Data           = bus.W_Data_In;
  assign bus.Stall            = 1'b0;
  assign bus.Load_Data        = zero_q ? 32'd0 : bus.R_Data;
  assign bus.Misaligned_Fault = mis_s & ~RST;

`endif

endmodule
